// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared RMII MAC constants and transmit state encoding
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/eth_crc32_d2.sv
// rtl/eth_crc32_d2.sv - reflected CRC-32 update over one dibit, bit 0 first
module eth_crc32_d2
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  // Two serial LFSR steps, low wire bit shifted in first.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_rmii.sv
// rtl/eth_tx_rmii.sv - RMII transmit framer: preamble, SFD, pad, FCS, IFG
module eth_tx_rmii #(
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_CYCLES  = 48
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  output logic       Tx_Busy,
  output logic       Tx_Underrun,
  output logic       Eth_Txen,
  output logic [1:0] Eth_Txd
);
  import eth_pkg::*;

  localparam logic [10:0] MIN_P   = 11'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_END = 16'(IFG_CYCLES - 1);

  tx_state_t   state, state_n;
  logic [1:0]  dcnt, dcnt_n;
  logic [15:0] cnt, cnt_n;
  logic [10:0] bcnt, bcnt_n, bcnt_inc;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic        txen_n;
  logic [1:0]  txd_n;
  logic        underrun_n;
  logic [2:0]  cur_idx, nxt_idx;
  logic [4:0]  fcs_idx;
  logic [1:0]  cur_dibit;

  assign cur_idx   = {dcnt, 1'b0};
  assign cur_dibit = byte_q[cur_idx +: 2];
  assign Tx_Busy   = (state != ST_IDLE);

  eth_crc32_d2 u_crc (
    .crc_in  (crc),
    .dibit   (cur_dibit),
    .crc_out (crc_upd)
  );

  // Next-state, handshake and the dibit to be driven in the state being entered.
  always_comb begin
    state_n    = state;
    dcnt_n     = dcnt + 2'd1;
    cnt_n      = cnt;
    bcnt_n     = bcnt;
    bcnt_inc   = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
    byte_n     = byte_q;
    last_n     = last_q;
    crc_n      = crc;
    Tx_Ready   = 1'b0;
    underrun_n = 1'b0;
    txen_n     = 1'b0;
    txd_n      = 2'b00;
    nxt_idx    = 3'd0;
    fcs_idx    = 5'd0;

    if (state == ST_DATA || state == ST_PAD) crc_n = crc_upd;

    case (state)
      ST_IDLE: begin
        dcnt_n = 2'd0;
        cnt_n  = 16'd0;
        bcnt_n = 11'd0;
        if (Tx_Valid) state_n = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (dcnt == 2'd3) begin
          if (cnt == 16'd6) begin
            state_n = ST_SFD;
            cnt_n   = 16'd0;
            crc_n   = CRC_INIT;
            bcnt_n  = 11'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      ST_SFD: begin
        if (dcnt == 2'd3) Tx_Ready = 1'b1;
      end
      ST_DATA: begin
        if (dcnt == 2'd3) begin
          if (!last_q) begin
            Tx_Ready = 1'b1;
          end else if (bcnt < MIN_P) begin
            state_n = ST_PAD;
            byte_n  = 8'h00;
            bcnt_n  = bcnt_inc;
          end else begin
            state_n = ST_FCS;
            cnt_n   = 16'd0;
          end
        end
      end
      ST_PAD: begin
        if (dcnt == 2'd3) begin
          if (bcnt < MIN_P) begin
            byte_n = 8'h00;
            bcnt_n = bcnt_inc;
          end else begin
            state_n = ST_FCS;
            cnt_n   = 16'd0;
          end
        end
      end
      ST_FCS: begin
        if (dcnt == 2'd3) begin
          if (cnt == 16'd3) begin
            state_n = ST_IFG;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      ST_IFG: begin
        if (cnt == IFG_END) begin
          state_n = ST_IDLE;
          dcnt_n  = 2'd0;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A ready cycle either takes the next byte or aborts the frame.
    if (Tx_Ready && Tx_Valid) begin
      state_n = ST_DATA;
      byte_n  = Tx_Data;
      last_n  = Tx_Last;
      bcnt_n  = bcnt_inc;
    end else if (Tx_Ready) begin
      state_n    = ST_IFG;
      cnt_n      = 16'd0;
      underrun_n = 1'b1;
    end

    nxt_idx = {dcnt_n, 1'b0};
    fcs_idx = {cnt_n[1:0], dcnt_n, 1'b0};
    case (state_n)
      ST_PREAMBLE: begin txen_n = 1'b1; txd_n = PREAMBLE_BYTE[nxt_idx +: 2]; end
      ST_SFD:      begin txen_n = 1'b1; txd_n = SFD_BYTE[nxt_idx +: 2]; end
      ST_DATA,
      ST_PAD:      begin txen_n = 1'b1; txd_n = byte_n[nxt_idx +: 2]; end
      ST_FCS:      begin txen_n = 1'b1; txd_n = ~crc_n[fcs_idx +: 2]; end
      default:     begin txen_n = 1'b0; txd_n = 2'b00; end
    endcase
  end

  // State, counters, CRC and registered PHY pins.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      dcnt        <= 2'd0;
      cnt         <= 16'd0;
      bcnt        <= 11'd0;
      byte_q      <= 8'h00;
      last_q      <= 1'b0;
      crc         <= CRC_INIT;
      Eth_Txen    <= 1'b0;
      Eth_Txd     <= 2'b00;
      Tx_Underrun <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      cnt         <= cnt_n;
      bcnt        <= bcnt_n;
      byte_q      <= byte_n;
      last_q      <= last_n;
      crc         <= crc_n;
      Eth_Txen    <= txen_n;
      Eth_Txd     <= txd_n;
      Tx_Underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_eth_tx_rmii.sv
// tb/tb_eth_tx_rmii.sv - randomized self-checking bench against a frame-level wire model
module tb_eth_tx_rmii;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] Tx_Data;
  logic       Tx_Valid, Tx_Last;
  logic       rdy0, busy0, ur0, txen0;
  logic [1:0] txd0;
  logic       rdy1, busy1, ur1, txen1;
  logic [1:0] txd1;

  always #10 Clk = ~Clk;

  eth_tx_rmii dut (
    .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Last(Tx_Last),
    .Tx_Ready(rdy0), .Tx_Busy(busy0), .Tx_Underrun(ur0), .Eth_Txen(txen0), .Eth_Txd(txd0)
  );

  eth_tx_rmii #(.MIN_PAYLOAD(0), .IFG_CYCLES(48)) dut_np (
    .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Last(Tx_Last),
    .Tx_Ready(rdy1), .Tx_Busy(busy1), .Tx_Underrun(ur1), .Eth_Txen(txen1), .Eth_Txd(txd1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0, first_acc;

  logic [1:0] cap0[$];
  logic [1:0] cap1[$];
  logic [1:0] exp_w[$];
  logic [7:0] fr[$];
  int hi[2], ifg_cnt[2], rise_cyc[2], last_hi[2], gap[2];
  int ur_cnt[2], busy_after[2], ur_txen_bad[2], idle_bad[2];
  logic trk[2], prev_txen[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Wire monitor for both instances.
  always @(negedge Clk) begin
    logic [1:0] txen_v, busy_v, ur_v;
    logic [1:0] txd_v[2];
    txen_v = {txen1, txen0};
    busy_v = {busy1, busy0};
    ur_v   = {ur1, ur0};
    txd_v[0] = txd0;
    txd_v[1] = txd1;
    for (int i = 0; i < 2; i++) begin
      if (txen_v[i]) begin
        if (i == 0) cap0.push_back(txd0);
        else        cap1.push_back(txd1);
        if (!prev_txen[i]) begin
          if (rise_cyc[i] < 0) rise_cyc[i] = cyc;
          if (last_hi[i] >= 0) gap[i] = cyc - last_hi[i];
        end
        hi[i]++;
        last_hi[i] = cyc;
      end else begin
        if (txd_v[i] != 2'b00) idle_bad[i]++;
        if (busy_v[i]) ifg_cnt[i]++;
      end
      if (ur_v[i]) begin
        ur_cnt[i]++;
        trk[i] = 1'b1;
        busy_after[i] = 0;
        if (txen_v[i]) ur_txen_bad[i]++;
      end
      if (trk[i]) begin
        if (busy_v[i]) busy_after[i]++;
        else trk[i] = 1'b0;
      end
      prev_txen[i] = txen_v[i];
    end
  end

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0; ifg_cnt[i] = 0; rise_cyc[i] = -1; last_hi[i] = -1; gap[i] = -1;
      ur_cnt[i] = 0; busy_after[i] = 0; ur_txen_bad[i] = 0; trk[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] crc_reg(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected Txen-high dibit stream; nkeep >= 0 means aborted after nkeep bytes.
  task automatic build_exp(input int minp, input int nkeep);
    logic [7:0] b[$];
    logic [7:0] body[$];
    logic [31:0] fcs;
    repeat (7) b.push_back(8'h55);
    b.push_back(8'hD5);
    if (nkeep >= 0) begin
      for (int i = 0; i < nkeep; i++) b.push_back(fr[i]);
    end else begin
      body = fr;
      while (body.size() < minp) body.push_back(8'h00);
      fcs = ~crc_reg(body);
      foreach (body[i]) b.push_back(body[i]);
      for (int j = 0; j < 4; j++) b.push_back(fcs[8*j +: 8]);
    end
    exp_w.delete();
    foreach (b[i]) for (int d = 0; d < 4; d++) exp_w.push_back(b[i][2*d +: 2]);
  endtask

  task automatic cmp_wire(input string tag, input int inst);
    int nm, sz;
    nm = 0;
    sz = (inst == 0) ? cap0.size() : cap1.size();
    chk({tag, "_len"}, sz, exp_w.size());
    for (int i = 0; i < sz && i < exp_w.size(); i++) begin
      if (((inst == 0) ? cap0[i] : cap1[i]) !== exp_w[i]) nm++;
    end
    chk({tag, "_dibits"}, nm, 0);
  endtask

  task automatic rand_frame(input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
  endtask

  task automatic send(input int drop_k);
    int n, k, guard;
    logic adv;
    n = fr.size(); k = 0; guard = 0; adv = 1'b0; first_acc = -1;
    @(posedge Clk); #1;
    c0 = cyc;
    Tx_Data = fr[0]; Tx_Last = (n == 1); Tx_Valid = 1'b1;
    while (guard < 3000) begin
      @(negedge Clk);
      guard++;
      if (adv) begin
        adv = 1'b0;
        k++;
        if (k == n) begin
          Tx_Valid = 1'b0; Tx_Last = 1'b0; Tx_Data = 8'h00;
          break;
        end
        Tx_Data = fr[k]; Tx_Last = (k == n - 1);
      end
      if (rdy0) begin
        if (first_acc < 0) first_acc = cyc - c0;
        if (k == drop_k) begin
          Tx_Valid = 1'b0; Tx_Last = 1'b0;
          break;
        end
        adv = 1'b1;
      end
    end
    if (guard >= 3000) begin
      chk("send_timeout", guard, 0);
      Tx_Valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge Clk);
    while ((busy0 || busy1) && guard < 5000) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 5000) chk("idle_timeout", {busy1, busy0}, 0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fw;
    logic [7:0]  rx[$];
    int n, sz;
    Rst = 1'b1; Tx_Valid = 1'b0; Tx_Last = 1'b0; Tx_Data = 8'h00;
    idle_bad[0] = 0; idle_bad[1] = 0; prev_txen[0] = 1'b0; prev_txen[1] = 1'b0;
    clear_caps();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_txen", txen0, 0);
    chk("rst_txd", txd0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_underrun", ur0, 0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);

    // 60-byte incrementing frame
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    clear_caps();
    send(-1);
    wait_idle();
    chk("f60_rise", rise_cyc[0] - c0, 1);
    chk("f60_first_accept", first_acc, 32);
    chk("f60_txen_high", hi[0], 288);
    chk("f60_ifg", ifg_cnt[0], 48);
    fw = 0;
    for (int i = 0; i < 16; i++) fw[2*i +: 2] = cap0[i];
    chk("f60_preamble_lo", fw, 32'h55555555);
    fw = 0;
    for (int i = 0; i < 16; i++) fw[2*i +: 2] = cap0[16 + i];
    chk("f60_preamble_sfd", fw, 32'hD5555555);
    build_exp(60, -1);
    cmp_wire("f60", 0);

    // "123456789" on the instance without padding
    fr.delete();
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_caps();
    send(-1);
    wait_idle();
    chk("chk_txen_high", hi[1], 84);
    sz = cap1.size();
    fw = 0;
    if (sz >= 16) for (int j = 0; j < 16; j++) fw[2*j +: 2] = cap1[sz - 16 + j];
    chk("chk_fcs", fw, 32'hCBF43926);
    rx = fr;
    for (int j = 0; j < 4; j++) rx.push_back(fw[8*j +: 8]);
    chk("chk_residue", crc_reg(rx), 32'hDEBB20E3);
    build_exp(0, -1);
    cmp_wire("chk_np", 1);

    // 14-byte frame padded to 60
    rand_frame(14);
    clear_caps();
    send(-1);
    wait_idle();
    chk("f14_txen_high", hi[0], 288);
    build_exp(60, -1);
    cmp_wire("f14", 0);
    build_exp(0, -1);
    cmp_wire("f14_np", 1);

    // Underrun at byte 5
    rand_frame(20);
    clear_caps();
    send(5);
    wait_idle();
    chk("ur_pulses", ur_cnt[0], 1);
    chk("ur_txen_low", ur_txen_bad[0], 0);
    chk("ur_busy_after", busy_after[0], 48);
    build_exp(60, 5);
    cmp_wire("ur", 0);

    // Back-to-back frames
    clear_caps();
    rand_frame(60);
    exp_w.delete();
    begin
      logic [1:0] w1[$];
      build_exp(60, -1);
      w1 = exp_w;
      send(-1);
      rand_frame(64);
      send(-1);
      wait_idle();
      build_exp(60, -1);
      exp_w = {w1, exp_w};
    end
    chk("b2b_gap", gap[0], 50);
    cmp_wire("b2b", 0);

    // Reset mid-frame, then a clean frame
    rand_frame(70);
    clear_caps();
    @(posedge Clk); #1;
    Tx_Data = fr[0]; Tx_Last = 1'b0; Tx_Valid = 1'b1;
    repeat (100) @(negedge Clk);
    Rst = 1'b1; Tx_Valid = 1'b0;
    @(negedge Clk);
    chk("mrst_txen", txen0, 0);
    chk("mrst_txd", txd0, 0);
    chk("mrst_ready", rdy0, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_underrun", ur_cnt[0], 0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    rand_frame(30);
    clear_caps();
    send(-1);
    wait_idle();
    build_exp(60, -1);
    cmp_wire("after_rst", 0);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 80);
      rand_frame(n);
      clear_caps();
      send(-1);
      wait_idle();
      chk($sformatf("rnd%0d_txen_high", r), hi[0], 32 + 4 * ((n > 60) ? n : 60) + 16);
      build_exp(60, -1);
      cmp_wire($sformatf("rnd%0d", r), 0);
      build_exp(0, -1);
      cmp_wire($sformatf("rnd%0d_np", r), 1);
    end

    chk("txd_zero_when_idle", idle_bad[0], 0);
    chk("txd_zero_when_idle_np", idle_bad[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_rmii.md
# eth_tx_rmii

RMII transmit MAC datapath for 100 Mb/s full-duplex links. Accepts a byte stream (destination MAC through end of payload) from `eth_tx_ctrl` over a valid/ready handshake. Wraps the stream with preamble, SFD, zero padding and FCS, then serializes it as dibits on the PHY pins. Enforces the inter-frame gap and reports underruns.

## Interface
- `MIN_PAYLOAD`, default 60: minimum number of bytes from the first data byte to the last pre-FCS byte; shorter frames are zero-padded. A value of 0 disables padding.
- `IFG_CYCLES`, default 48: number of idle clock cycles (Txen low) after each frame (12 byte times).
- `Clk`  in  1  50 MHz RMII reference clock; the block's single clock.
- `Rst`  in  1  synchronous, active-high reset.
- `Tx_Data`  in  8  payload byte.
- `Tx_Valid`  in  1  `Tx_Data`/`Tx_Last` are valid.
- `Tx_Last`  in  1  current byte is the final byte of the frame.
- `Tx_Ready`  out  1  byte is consumed this cycle if `Tx_Valid`.
- `Tx_Busy`  out  1  a frame or its IFG is in progress.
- `Tx_Underrun`  out  1  one-cycle pulse; the frame was aborted.
- `Eth_Txen`  out  1  RMII TX_EN.
- `Eth_Txd`  out  2  RMII TXD[1:0].

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- Each byte occupies 4 cycles, LSB dibit first: cycle 0 drives bits [1:0], cycle 3 drives bits [7:6].
- A 2-bit dibit counter advances only outside IDLE.
- IDLE → PREAMBLE when `Tx_Valid`=1. The first byte is not consumed yet; `Tx_Data` must stay stable.
- PREAMBLE sends 7 × 0x55 (28 cycles), then goes to SFD.
- SFD sends 0xD5 (4 cycles), then goes to DATA.
- `Tx_Ready` is 1 only in two places:
  - the final dibit cycle of SFD;
  - the final dibit cycle of each DATA byte that was not flagged `Tx_Last`.
- `Tx_Ready` is combinational from state/counter only and never depends on `Tx_Valid`.
- Underrun: `Tx_Ready`=1 with `Tx_Valid`=0.
  - `Tx_Underrun` pulses.
  - Next state is IFG, so `Eth_Txen` drops on the next cycle and no FCS is sent.
- After the `Tx_Last` byte is fully shifted:
  - go to PAD if the byte count is below `MIN_PAYLOAD`, otherwise go to FCS.
  - PAD sends 0x00 bytes until the count equals `MIN_PAYLOAD`.
- Byte counter: 11 bits, counts DATA and PAD bytes, and saturates at 2047. There is no maximum-length enforcement.
- CRC-32:
  - reflected polynomial 0xEDB88320;
  - initialised to 0xFFFFFFFF on entry to SFD;
  - updated per dibit over DATA and PAD only.
- FCS sends ~crc, bit 0 first (16 cycles), then goes to IFG.
- IFG: `Eth_Txen`=0 and `Eth_Txd`=00 for `IFG_CYCLES` cycles, then IDLE. `Tx_Valid` is ignored during IFG.
- `Tx_Busy` = (state != IDLE).

## Timing
- Reset values: `Eth_Txen`=0, `Eth_Txd`=00, `Tx_Ready`=0, `Tx_Busy`=0, `Tx_Underrun`=0; state IDLE, counters 0, CRC 0xFFFFFFFF.
- `Eth_Txen`/`Eth_Txd` are registered.
- Taking `Tx_Valid` first seen in IDLE as cycle 0:
  - `Eth_Txen` rises at cycle 1.
  - Preamble runs cycles 1–28, SFD runs cycles 29–32.
  - The first byte is accepted at cycle 32 and driven on cycles 33–36.
  - Byte k (from 0) is accepted at cycle 32+4k.
- `Eth_Txen` high time per frame = 32 + 4·max(N, MIN_PAYLOAD) + 16 cycles.
- Next frame: the earliest `Tx_Valid` sampling is the first IDLE cycle after IFG, so back-to-back frames are spaced by exactly `IFG_CYCLES` idle cycles plus 1 IDLE cycle.
- Reset mid-frame: `Eth_Txen`=0 on the following cycle. No FCS is sent and no `Tx_Underrun` is raised.
- `Tx_Underrun` is asserted for exactly the cycle after the failed handshake, i.e. the first IFG cycle.

## Structure
- Shared package `eth_pkg` holds: PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_POLY 32'hEDB88320, CRC_INIT 32'hFFFFFFFF, CRC_RESIDUE 32'hDEBB20E3, and the state encoding.
- Sub-module `eth_crc32_d2`: combinational 2-bit-per-step CRC-32 update (crc_in, dibit → crc_out). It is reused later by the RMII receive path.

## Test plan
- 60-byte frame 0x00..0x3B, `Tx_Valid` held:
  - Txen high for exactly 288 cycles;
  - 28 preamble dibit cycles of 01 followed by SFD dibits 01,01,01,11;
  - FCS matches a reference CRC;
  - 48 idle cycles follow.
- `MIN_PAYLOAD`=0, payload ASCII "123456789": FCS bytes on the wire are 0x26, 0x39, 0xF4, 0xCB; a receiver CRC over data+FCS equals residue 0xDEBB20E3.
- 14-byte frame with default parameters: 46 bytes of 0x00 appended, Txen high 288 cycles, FCS covers the pad.
- `Tx_Valid` dropped at byte 5's `Tx_Ready` cycle:
  - `Tx_Underrun` pulses once;
  - Txen falls the next cycle with no FCS;
  - `Tx_Busy` stays high for 48 more cycles.
- Two frames offered back to back: the second frame's Txen rises exactly 50 cycles after the first frame's Txen falls (48 IFG cycles, the IDLE sampling cycle, and the registered-output delay).
- `Rst` asserted at cycle 100 of a frame: outputs at reset values next cycle; a new frame offered afterwards transmits correctly with fresh CRC.
